// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a standard-mode FIFO read port into a 2-entry valid/ready stream buffer
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   fifo_dout/empty/prog_empty   FIFO read side (dout valid the cycle after fifo_rd_en)
//   fifo_rd_en                   FIFO read strobe
//   burst_mode, flush            start gating: wait for !prog_empty unless flushing
//   m_data/m_valid/m_ready       output stream
//   rd_count                     completed stream beats (wraps)
//   busy                         high whenever the controller is not idle
module fifo_rd_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_prog_empty,
    output logic             fifo_rd_en,
    input  logic             burst_mode,
    input  logic             flush,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t           state;
    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] head, tail;
    logic             pop, start, done;
    logic [1:0]       occ_pop;
    assign pop        = m_valid & m_ready;
    assign m_valid    = occ != 2'd0;
    assign m_data     = head;
    assign busy       = state != IDLE;
    assign start      = !fifo_empty & (!burst_mode | !fifo_prog_empty | flush);
    // occupancy left after this cycle's pop; the in-flight word lands on top of it
    assign occ_pop    = occ - {1'b0, pop};
    assign done       = !inflight & (occ_pop == 2'd0);
    // a read is only issued when its word is guaranteed a free slot on arrival
    assign fifo_rd_en = (state == RUN) & !fifo_empty & ((occ_pop + {1'b0, inflight}) < 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ_pop + {1'b0, inflight};
            if (pop) begin
                head     <= tail;
                rd_count <= rd_count + CNT_W'(1);
            end
            // the arriving word goes into the first free slot after the pop shift
            if (inflight && occ_pop == 2'd0) head <= fifo_dout;
            if (inflight && occ_pop == 2'd1) tail <= fifo_dout;
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (fifo_empty) state <= DRAIN;
                DRAIN:   state <= start ? RUN : done ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model plus stream scoreboard around fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int W     = 32;
    localparam int DEPTH = 512;
    localparam int PE_TH = 8;

    logic         clk = 1'b0, rst = 1'b1;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_empty = 1'b1, fifo_prog_empty = 1'b1;
    logic         fifo_rd_en;
    logic         burst_mode = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic [31:0]  rd_count;
    logic         busy;
    logic         wr_en = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] fq[$];
    logic [W-1:0] wr_hist[$];
    int           rd_cyc[$], pop_cyc[$];
    int           checks = 0, errors = 0;
    int           cyc = 0;
    int           exp_idx = 0, outstanding = 0, beats = 0;
    logic         stalled = 1'b0;
    logic [W-1:0] held = '0;
    int           rmode = 0, rphase = 0;
    logic [W-1:0] next_val = '0;

    typedef struct {
        int nwords;
        bit burst;
        bit fl;
        bit pre_rst;
        int rm;
        int exp_beats;
    } vec_t;
    vec_t vt[6];

    fifo_rd_stream #(.WIDTH(W), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_prog_empty(fifo_prog_empty), .fifo_rd_en(fifo_rd_en), .burst_mode(burst_mode),
        .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .rd_count(rd_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 512-deep standard-mode FIFO: dout registered on a read, flags registered
    always @(posedge clk) begin
        int sz;
        sz = fq.size();
        if (fifo_rd_en && sz > 0) fifo_dout <= fq.pop_front();
        if (wr_en && sz < DEPTH) begin
            fq.push_back(din);
            wr_hist.push_back(din);
        end
        fifo_empty      <= fq.size() == 0;
        fifo_prog_empty <= fq.size() < PE_TH;
    end

    // scoreboard: beats must replay the FIFO write history in order
    always @(negedge clk) begin
        if (rst) begin
            exp_idx     = wr_hist.size() - fq.size();
            outstanding = 0;
            beats       = 0;
            stalled     = 1'b0;
        end else begin
            check("rd_while_empty", fifo_rd_en && fifo_empty, 0);
            check("buffer_bound", outstanding <= 2, 1);
            check("valid_backed", m_valid && outstanding == 0, 0);
            check("rd_count", rd_count, beats);
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, held);
            end
            if (fifo_rd_en) begin
                rd_cyc.push_back(cyc);
                outstanding++;
            end
            if (m_valid && m_ready) begin
                pop_cyc.push_back(cyc);
                check("beat_expected", exp_idx < wr_hist.size(), 1);
                if (exp_idx < wr_hist.size()) check("beat_data", m_data, wr_hist[exp_idx]);
                exp_idx++;
                outstanding--;
                beats++;
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
        end
    end

    task automatic tick();
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = (rphase % 3) == 0;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        rphase++;
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            din   = next_val;
            next_val++;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic reset_on();
        rst = 1'b1;
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_count", rd_count, 0);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(fifo_empty && !busy && !m_valid) && n < 3000);
        check(name, fifo_empty && !busy && !m_valid, 1);
    endtask

    initial begin
        int r0, p0, k, rem, h0;
        vt[0] = '{3, 1'b0, 1'b0, 1'b0, 0, 3};
        vt[1] = '{513, 1'b0, 1'b0, 1'b1, 0, 512};
        vt[2] = '{20, 1'b0, 1'b0, 1'b0, 1, 20};
        vt[3] = '{12, 1'b1, 1'b0, 1'b0, 0, 12};
        vt[4] = '{30, 1'b0, 1'b0, 1'b1, 2, 30};
        vt[5] = '{7, 1'b1, 1'b1, 1'b0, 1, 7};
        tick();
        tick();

        for (int i = 0; i < 6; i++) begin
            reset_on();
            tick();
            next_val   = '0;
            burst_mode = vt[i].burst;
            flush      = vt[i].fl;
            rmode      = vt[i].rm;
            if (!vt[i].pre_rst) rst = 1'b0;
            write_words(vt[i].nwords);
            rst = 1'b0;
            wait_idle("vec_drain");
            check("vec_rd_count", rd_count, vt[i].exp_beats);
            check("vec_busy", busy, 0);
            check("vec_all_out", exp_idx, wr_hist.size());
        end
        burst_mode = 1'b0;
        flush      = 1'b0;

        // latency: first write -> RUN next cycle -> rd_en -> m_valid two cycles later
        reset_on();
        tick();
        rst      = 1'b0;
        rmode    = 0;
        next_val = '0;
        r0 = rd_cyc.size();
        p0 = pop_cyc.size();
        wr_en = 1'b1;
        din   = next_val;
        next_val++;
        tick();
        k = cyc;
        write_words(2);
        wait_idle("lat_drain");
        check("lat_rd_pulses", rd_cyc.size() - r0, 3);
        check("lat_first_rd", rd_cyc[r0], k + 1);
        check("lat_rd_run", rd_cyc[r0 + 2], k + 3);
        check("lat_first_valid", pop_cyc[p0], k + 3);
        check("lat_beats_back2back", pop_cyc[p0 + 2], k + 5);
        check("lat_rd_count", rd_count, 3);

        // no backpressure relief: exactly two reads fill the buffer
        reset_on();
        tick();
        rst      = 1'b0;
        rmode    = 3;
        next_val = '0;
        r0 = rd_cyc.size();
        write_words(10);
        for (int i = 0; i < 30; i++) tick();
        check("stall_rd_pulses", rd_cyc.size() - r0, 2);
        check("stall_hold_valid", m_valid, 1);
        check("stall_hold_data", m_data, 0);
        check("stall_busy", busy, 1);
        rmode = 0;
        wait_idle("stall_drain");
        check("stall_rd_total", rd_cyc.size() - r0, 10);
        check("stall_rd_count", rd_count, 10);

        // burst gating below the prog_empty threshold, released by flush
        reset_on();
        tick();
        rst        = 1'b0;
        burst_mode = 1'b1;
        next_val   = '0;
        r0 = rd_cyc.size();
        write_words(5);
        for (int i = 0; i < 100; i++) tick();
        check("gate_no_rd", rd_cyc.size() - r0, 0);
        check("gate_busy", busy, 0);
        flush = 1'b1;
        wait_idle("gate_flush_drain");
        check("gate_rd_count", rd_count, 5);
        flush      = 1'b0;
        burst_mode = 1'b0;

        // reset in the middle of a 100-word drain
        reset_on();
        next_val = '0;
        write_words(100);
        rst = 1'b0;
        p0 = pop_cyc.size();
        for (int i = 0; i < 200 && pop_cyc.size() - p0 < 50; i++) tick();
        check("mid_reached_50", pop_cyc.size() - p0, 50);
        rem = fq.size();
        reset_on();
        tick();
        check("mid_idle", busy, 0);
        tick();
        rst = 1'b0;
        wait_idle("mid_drain");
        check("mid_rd_count", rd_count, rem);
        check("mid_all_out", exp_idx, wr_hist.size());

        // randomized traffic, mode changes and backpressure
        reset_on();
        tick();
        rst   = 1'b0;
        rmode = 2;
        h0 = wr_hist.size();
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                burst_mode = 1'($urandom_range(0, 1));
                flush      = $urandom_range(0, 3) == 0;
            end
            wr_en = $urandom_range(0, 2) != 0 && fq.size() < 500;
            din   = $urandom;
            tick();
        end
        wr_en = 1'b0;
        flush = 1'b1;
        rmode = 0;
        wait_idle("rand_drain");
        check("rand_all_out", exp_idx, wr_hist.size());
        check("rand_rd_count", rd_count, wr_hist.size() - h0);
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Downstream stage of the 512-deep sync FIFO.
- Drains the FIFO's standard-mode read port (rd_en, with dout valid one cycle later) and re-presents the data as a valid/ready stream through a 2-entry output buffer.
- Supports burst gating via the FIFO's prog_empty, so reads start only once a programmable amount of data is queued.
- Keeps a running count of delivered beats.

Parameters:
- WIDTH, `WIDTH (32): data width; must match FIFO din/dout.
- CNT_W, 32: width of the delivered-beat counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_dout  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_prog_empty  in  1  FIFO programmable-empty flag
- fifo_rd_en  out  1  FIFO read strobe
- burst_mode  in  1  1: start draining only when fifo_prog_empty=0; 0: start on any data
- flush  in  1  level; overrides burst gating so the FIFO drains to empty
- m_data  out  WIDTH  stream data (head of output buffer)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- rd_count  out  CNT_W  number of completed m_valid&m_ready beats
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; buffer occupancy occ=0; inflight=0; m_valid=0; m_data=0; rd_count=0; busy=0; fifo_rd_en=0.
- Reset mid-operation discards in-flight read data and buffered data. Data already popped from the FIFO is lost (accepted).
- fifo_rd_en is combinational:
  - fifo_rd_en = (state==RUN) & !fifo_empty & ((occ + inflight - pop) < 2), where pop = m_valid & m_ready.
  - Never asserted while fifo_empty=1.
- inflight (1 bit) is a register equal to last cycle's fifo_rd_en. When inflight=1, fifo_dout is written into the buffer tail at that cycle's edge.
- Buffer: 2-entry FIFO of registers.
  - m_data/m_valid come from the head; m_valid = (occ != 0).
  - A simultaneous pop and capture in the same cycle is legal; occ is unchanged.
  - occ + inflight never exceeds 2. Nothing is ever dropped.
  - m_data stays stable while m_valid=1 and m_ready=0.
- Throughput: with m_ready held at 1 and FIFO non-empty, one beat per cycle sustained.
- Latency: fifo_rd_en in cycle n -> data on m_data with m_valid=1 in cycle n+2.
- FSM (registered transitions):
  - IDLE -> RUN when !fifo_empty & (!burst_mode | !fifo_prog_empty | flush).
  - RUN -> DRAIN when fifo_empty=1 (no further reads issued).
  - RUN stays in RUN when the FIFO refills before empty is seen.
  - DRAIN -> IDLE when inflight=0 & occ=0, or when occ becomes 0 by pop that cycle with inflight=0.
  - DRAIN -> RUN when fifo_empty=0 again and the start condition holds.
- Empty-to-first-read latency: fifo_empty falls in cycle k (start condition true) -> state RUN at k+1 -> fifo_rd_en at k+1 -> m_valid at k+3.
- burst_mode changes are sampled only in IDLE. Once RUN is entered, draining continues until the FIFO is empty.
- rd_count increments on each pop and wraps modulo 2^CNT_W.

Test Plan:
- Reset, write 3 words (0,1,2) into FIFO, burst_mode=0, m_ready=1 -> fifo_rd_en 3 consecutive cycles; m_data 0,1,2 on consecutive cycles starting 2 cycles after first rd_en; rd_count=3; return to IDLE, busy=0.
- Fill FIFO with 513 writes (512 stored, full=1), m_ready=1 -> 512 beats back-to-back values 0..511; fifo_rd_en never high with fifo_empty=1; rd_count=512.
- burst_mode=1, write 5 words (prog_empty still 1) -> no fifo_rd_en for 1000 ns. Then assert flush -> 5 beats 0..4 delivered.
- Backpressure: 20 words queued, m_ready toggles 1,0,0,1,... -> every value 0..19 delivered exactly once in order; occ+inflight <= 2; m_data stable while stalled.
- m_ready=0 throughout with 10 words queued -> exactly 2 fifo_rd_en pulses, m_valid=1 holding value 0; then m_ready=1 -> remaining 8 read, values 0..9 in order.
- Assert rst mid-burst (cycle 50 of 100 queued) -> outputs immediately 0, state IDLE; after release, draining resumes from the FIFO's current head with no spurious m_valid.
